regfile_wb_arbiter: RTL and testbench



---
 rtl/regfile_wb_arbiter.sv | 163 ++++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - write-port arbiter and clear sequencer for the 32x32 register file
//
// Purpose:
//   Shares the register file's single write port between two writeback
//   requesters (A = ALU, B = load unit). When both are valid, a round-robin
//   pointer picks the winner. The optional bulk-clear sequence zeroes
//   registers 1..31. WriteRegister, WriteData and RegWrite are registered and
//   drive the register file directly.
//
// Configuration macro:
//   WB_CLEAR_EN - when defined, compiles in the CLEAR state, the sweep counter
//                 and the Busy logic. When it is undefined, Clear is ignored
//                 and Busy is tied to 0.
//
// Ports:
//   Clk, ResetN           clock, asynchronous active-low reset
//   ValidA/AddrA/DataA    requester A write request
//   ReadyA                A accepted this cycle (combinational)
//   ValidB/AddrB/DataB    requester B write request
//   ReadyB                B accepted this cycle (combinational)
//   Clear                 single-cycle pulse that starts the clear sweep
//   Busy                  clear sweep in progress (registered)
//   WriteRegister         register file write address (registered)
//   WriteData             register file write data (registered)
//   RegWrite              register file write enable (registered)

module regfile_wb_arbiter (
    input  logic        Clk,
    input  logic        ResetN,
    input  logic        ValidA,
    input  logic [4:0]  AddrA,
    input  logic [31:0] DataA,
    output logic        ReadyA,
    input  logic        ValidB,
    input  logic [4:0]  AddrB,
    input  logic [31:0] DataB,
    output logic        ReadyB,
    input  logic        Clear,
    output logic        Busy,
    output logic [4:0]  WriteRegister,
    output logic [31:0] WriteData,
    output logic        RegWrite
);

    // ptr_q = 0 favours A, ptr_q = 1 favours B.
    logic        ptr_q, ptr_d;
    logic [4:0]  wreg_q, wreg_d;
    logic [31:0] wdata_q, wdata_d;
    logic        regwrite_q, regwrite_d;
    logic        accept_en;
    logic        grant_a, grant_b;

`ifdef WB_CLEAR_EN
    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    state_t      state_q, state_d;
    // count_q holds the register number currently presented on WriteRegister
    // during a sweep, so the sweep ends once register 31 has been shown.
    logic [4:0]  count_q, count_d;
    logic        busy_q, busy_d;

    // A Clear request pre-empts any request in the same cycle.
    assign accept_en = (state_q == S_IDLE) && !Clear;
    assign Busy      = busy_q;
`else
    logic        unused_clear;

    assign unused_clear = Clear;
    assign accept_en    = 1'b1;
    assign Busy         = 1'b0;
`endif

    assign grant_a = accept_en && ValidA && (!ValidB || !ptr_q);
    assign grant_b = accept_en && ValidB && (!ValidA ||  ptr_q);

    // Gating with ResetN keeps both Ready outputs low while reset is held,
    // even if requesters are already valid.
    assign ReadyA = ResetN && grant_a;
    assign ReadyB = ResetN && grant_b;

    always_comb begin
        ptr_d      = ptr_q;
        wreg_d     = wreg_q;
        wdata_d    = wdata_q;
        regwrite_d = 1'b0;
`ifdef WB_CLEAR_EN
        state_d    = state_q;
        count_d    = count_q;
        busy_d     = busy_q;
`endif

        if (grant_a) begin
            wreg_d     = AddrA;
            wdata_d    = DataA;
            regwrite_d = (AddrA != 5'd0);
            ptr_d      = 1'b1;
        end else if (grant_b) begin
            wreg_d     = AddrB;
            wdata_d    = DataB;
            regwrite_d = (AddrB != 5'd0);
            ptr_d      = 1'b0;
        end

`ifdef WB_CLEAR_EN
        case (state_q)
            S_IDLE: begin
                if (Clear) begin
                    // The write to register 1 is issued on the same edge that
                    // enters CLEAR. This makes Busy and the first write appear
                    // together.
                    state_d    = S_CLEAR;
                    count_d    = 5'd1;
                    busy_d     = 1'b1;
                    wreg_d     = 5'd1;
                    wdata_d    = 32'd0;
                    regwrite_d = 1'b1;
                end
            end
            S_CLEAR: begin
                if (count_q == 5'd31) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    count_d    = count_q + 5'd1;
                    wreg_d     = count_q + 5'd1;
                    wdata_d    = 32'd0;
                    regwrite_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
`endif
    end

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            ptr_q      <= 1'b0;
            wreg_q     <= 5'd0;
            wdata_q    <= 32'd0;
            regwrite_q <= 1'b0;
`ifdef WB_CLEAR_EN
            state_q    <= S_IDLE;
            count_q    <= 5'd1;
            busy_q     <= 1'b0;
`endif
        end else begin
            ptr_q      <= ptr_d;
            wreg_q     <= wreg_d;
            wdata_q    <= wdata_d;
            regwrite_q <= regwrite_d;
`ifdef WB_CLEAR_EN
            state_q    <= state_d;
            count_q    <= count_d;
            busy_q     <= busy_d;
`endif
        end
    end

    assign WriteRegister = wreg_q;
    assign WriteData     = wdata_q;
    assign RegWrite      = regwrite_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed self-checking bench for regfile_wb_arbiter

module tb_regfile_wb_arbiter;

    logic        Clk = 1'b0;
    logic        ResetN;
    logic        ValidA, ValidB, Clear;
    logic [4:0]  AddrA, AddrB;
    logic [31:0] DataA, DataB;
    logic        ReadyA, ReadyB, Busy, RegWrite;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData;

    logic [31:0] rf [32];
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 Clk = ~Clk;

    regfile_wb_arbiter dut (
        .Clk           (Clk),
        .ResetN        (ResetN),
        .ValidA        (ValidA),
        .AddrA         (AddrA),
        .DataA         (DataA),
        .ReadyA        (ReadyA),
        .ValidB        (ValidB),
        .AddrB         (AddrB),
        .DataB         (DataB),
        .ReadyB        (ReadyB),
        .Clear         (Clear),
        .Busy          (Busy),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .RegWrite      (RegWrite)
    );

    // Plain storage array standing in for the register file. Register 0 is
    // not hardwired here, so a stray write to it would be visible.
    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    end
    always @(posedge Clk) begin
        if (RegWrite) rf[WriteRegister] <= WriteData;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk_wr(input string tag, input logic rw, input logic [4:0] reg_n, input logic [31:0] data);
        chk({tag, "_rw"},   {31'd0, RegWrite}, {31'd0, rw});
        chk({tag, "_reg"},  {27'd0, WriteRegister}, {27'd0, reg_n});
        chk({tag, "_data"}, WriteData, data);
    endtask

    initial begin
        ResetN = 1'b0;
        ValidA = 1'b1; AddrA = 5'd3; DataA = 32'hAAAA0001;
        ValidB = 1'b1; AddrB = 5'd4; DataB = 32'hBBBB0002;
        Clear  = 1'b0;

        // Reset state with both requesters already valid.
        @(negedge Clk); #1;
        chk("rst_ready_a", {31'd0, ReadyA}, 32'd0);
        chk("rst_ready_b", {31'd0, ReadyB}, 32'd0);
        chk("rst_busy",    {31'd0, Busy},   32'd0);
        chk_wr("rst", 1'b0, 5'd0, 32'd0);

        // Contention: grants alternate A,B,A,B; writes follow one cycle later.
        @(negedge Clk);
        ResetN = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("cont_ready_a", {31'd0, ReadyA}, (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("cont_ready_b", {31'd0, ReadyB}, (i % 2 == 0) ? 32'd0 : 32'd1);
            tick();
            if (i % 2 == 0) chk_wr("cont_wr_a", 1'b1, 5'd3, 32'hAAAA0001);
            else            chk_wr("cont_wr_b", 1'b1, 5'd4, 32'hBBBB0002);
            @(negedge Clk);
        end

        // Idle cycle: RegWrite clears, the address is held.
        ValidA = 1'b0; ValidB = 1'b0;
        #1;
        chk("idle_ready_a", {31'd0, ReadyA}, 32'd0);
        chk("idle_ready_b", {31'd0, ReadyB}, 32'd0);
        tick();
        chk_wr("idle", 1'b0, 5'd4, 32'hBBBB0002);

        // B streams three writes back to back.
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            ValidB = 1'b1; AddrB = 5'd5 + 5'(i); DataB = 32'hB000_0000 + 32'(i);
            #1;
            chk("strm_ready_b", {31'd0, ReadyB}, 32'd1);
            tick();
            chk_wr("strm_wr", 1'b1, 5'd5 + 5'(i), 32'hB000_0000 + 32'(i));
        end

        // Address 0: the request is accepted, but no write is issued.
        @(negedge Clk);
        ValidB = 1'b0;
        ValidA = 1'b1; AddrA = 5'd0; DataA = 32'hFFFFFFFF;
        #1;
        chk("r0_ready_a", {31'd0, ReadyA}, 32'd1);
        tick();
        chk_wr("r0_wr", 1'b0, 5'd0, 32'hFFFFFFFF);

        // The A grant at address 0 still moved the pointer, so B now wins contention.
        @(negedge Clk);
        AddrA = 5'd11; DataA = 32'h1111_0011;
        ValidB = 1'b1; AddrB = 5'd12; DataB = 32'h2222_0012;
        #1;
        chk("ptr_ready_a", {31'd0, ReadyA}, 32'd0);
        chk("ptr_ready_b", {31'd0, ReadyB}, 32'd1);
        tick();
        chk_wr("ptr_wr", 1'b1, 5'd12, 32'h2222_0012);
        chk("r0_read", rf[0], 32'd0);

`ifdef WB_CLEAR_EN
        // Preload reg9, then clear while A is still requesting.
        @(negedge Clk);
        ValidB = 1'b0;
        ValidA = 1'b1; AddrA = 5'd9; DataA = 32'h12345678;
        tick();
        @(negedge Clk);
        AddrA = 5'd20; DataA = 32'h0000DEAD; Clear = 1'b1;
        #1;
        chk("clr_ready_a0", {31'd0, ReadyA}, 32'd0);
        tick();
        chk("clr_busy1", {31'd0, Busy}, 32'd1);
        chk_wr("clr_wr1", 1'b1, 5'd1, 32'd0);
        @(negedge Clk);
        Clear = 1'b0;
        for (int k = 2; k <= 31; k++) begin
            Clear = (k == 10);   // a second pulse mid-sweep must be ignored
            #1;
            chk("clr_ready_a", {31'd0, ReadyA}, 32'd0);
            tick();
            chk_wr("clr_wr", 1'b1, 5'(k), 32'd0);
            chk("clr_busy", {31'd0, Busy}, 32'd1);
            @(negedge Clk);
        end
        Clear = 1'b0;
        #1;
        chk("clr_ready_last", {31'd0, ReadyA}, 32'd0);
        tick();
        chk("clr_busy_drop", {31'd0, Busy}, 32'd0);
        chk("clr_rw_drop",   {31'd0, RegWrite}, 32'd0);
        chk("clr_reg9",  rf[9],  32'd0);
        chk("clr_reg31", rf[31], 32'd0);
        @(negedge Clk); #1;
        chk("clr_ready_after", {31'd0, ReadyA}, 32'd1);
        tick();
        chk_wr("clr_after_wr", 1'b1, 5'd20, 32'h0000DEAD);

        // Reset during a sweep, then start a new sweep from register 1.
        @(negedge Clk);
        ValidA = 1'b0; Clear = 1'b1;
        tick();
        @(negedge Clk);
        Clear = 1'b0;
        for (int k = 2; k <= 10; k++) tick();
        chk("mid_reg10", {27'd0, WriteRegister}, 32'd10);
        ResetN = 1'b0;
        #1;
        chk("mid_busy", {31'd0, Busy}, 32'd0);
        chk_wr("mid_rst", 1'b0, 5'd0, 32'd0);
        @(negedge Clk);
        ResetN = 1'b1; Clear = 1'b1;
        tick();
        chk("restart_busy", {31'd0, Busy}, 32'd1);
        chk_wr("restart_wr", 1'b1, 5'd1, 32'd0);
        @(negedge Clk);
        Clear = 1'b0;
        for (int k = 0; k < 32; k++) tick();
        chk("restart_done", {31'd0, Busy}, 32'd0);
`else
        // Clear is ignored: A is accepted in the same cycle and Busy stays low.
        @(negedge Clk);
        ValidB = 1'b0;
        ValidA = 1'b1; AddrA = 5'd2; DataA = 32'h22222222; Clear = 1'b1;
        #1;
        chk("noclr_ready_a", {31'd0, ReadyA}, 32'd1);
        tick();
        chk("noclr_busy", {31'd0, Busy}, 32'd0);
        chk_wr("noclr_wr", 1'b1, 5'd2, 32'h22222222);
        @(negedge Clk);
        Clear = 1'b0; ValidA = 1'b0;
        tick();
        chk("noclr_reg2", rf[2], 32'h22222222);
        chk("noclr_rw_drop", {31'd0, RegWrite}, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
